// File: rtl/reorder_buffer_pkg.sv
// reorder_buffer_pkg: ROB tag width, capacity, null constants and the 15->1 pointer successor
package reorder_buffer_pkg;
    localparam int ENTRY_SIZE = 4;
    localparam int ROB_CAP = (1 << ENTRY_SIZE) - 1;
    localparam int ROB_SLOTS = 1 << ENTRY_SIZE;
    typedef logic [ENTRY_SIZE-1:0] entry_t;
    localparam entry_t ENTRY_NULL = '0;
    localparam logic [5:0] NULL = 6'd0;
    localparam logic TRUE = 1'b1;
    localparam logic FALSE = 1'b0;
    function automatic entry_t next_ptr(input entry_t p);
        return (p == entry_t'(ROB_CAP)) ? entry_t'(1) : p + entry_t'(1);
    endfunction
endpackage

// File: rtl/reorder_buffer.sv
// reorder_buffer: tag allocation, CDB capture, operand forwarding, in-order commit and mispredict flush
module reorder_buffer
    import reorder_buffer_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  issue_valid,
    input  logic [5:0]            issue_rd,
    input  logic                  issue_is_branch,
    input  logic                  issue_pred_taken,
    output logic                  issue_ready,
    output logic                  new_issue,
    output logic [ENTRY_SIZE-1:0] rob_new_entry,
    input  logic                  cdb_valid,
    input  logic [ENTRY_SIZE-1:0] cdb_entry,
    input  logic [31:0]           cdb_value,
    input  logic                  cdb_taken,
    input  logic [31:0]           cdb_target,
    input  logic [ENTRY_SIZE-1:0] query_j_entry,
    input  logic [ENTRY_SIZE-1:0] query_k_entry,
    output logic                  query_j_ready,
    output logic                  query_k_ready,
    output logic [31:0]           query_j_value,
    output logic [31:0]           query_k_value,
    output logic                  rob_commit,
    output logic [ENTRY_SIZE-1:0] rob_entry,
    output logic [5:0]            rob_des,
    output logic [31:0]           rob_result,
    output logic                  roll_back,
    output logic [31:0]           roll_back_pc
);
    logic [ROB_SLOTS-1:0]  r_busy;
    logic [ROB_SLOTS-1:0]  r_ready;
    logic [ROB_SLOTS-1:0]  r_is_branch;
    logic [ROB_SLOTS-1:0]  r_pred_taken;
    logic [ROB_SLOTS-1:0]  r_taken;
    logic [5:0]            r_rd     [ROB_SLOTS];
    logic [31:0]           r_value  [ROB_SLOTS];
    logic [31:0]           r_target [ROB_SLOTS];
    entry_t                r_head;
    entry_t                r_tail;
    entry_t                r_count;
    logic                  w_head_done;
    logic                  w_mispredict;
    logic                  w_commit;
    logic                  w_wb;

    assign issue_ready   = (r_count != entry_t'(ROB_CAP)) && !roll_back;
    assign new_issue     = issue_valid && issue_ready && rdy_in;
    assign rob_new_entry = r_tail;
    assign w_head_done   = r_busy[r_head] && r_ready[r_head];
    assign w_mispredict  = w_head_done && r_is_branch[r_head] && (r_taken[r_head] != r_pred_taken[r_head]);
    assign w_commit      = w_head_done && !w_mispredict;
    assign w_wb          = cdb_valid && !roll_back && r_busy[cdb_entry];

    assign query_j_ready = (query_j_entry == ENTRY_NULL) || (cdb_valid && cdb_entry == query_j_entry) || r_ready[query_j_entry];
    assign query_j_value = (query_j_entry == ENTRY_NULL) ? 32'd0 :
                           (cdb_valid && cdb_entry == query_j_entry) ? cdb_value : r_value[query_j_entry];
    assign query_k_ready = (query_k_entry == ENTRY_NULL) || (cdb_valid && cdb_entry == query_k_entry) || r_ready[query_k_entry];
    assign query_k_value = (query_k_entry == ENTRY_NULL) ? 32'd0 :
                           (cdb_valid && cdb_entry == query_k_entry) ? cdb_value : r_value[query_k_entry];

    always_ff @(posedge clk) begin
        if (rst_in) begin
            r_busy       <= '0;
            r_ready      <= '0;
            r_head       <= entry_t'(1);
            r_tail       <= entry_t'(1);
            r_count      <= '0;
            rob_commit   <= FALSE;
            rob_entry    <= ENTRY_NULL;
            rob_des      <= NULL;
            rob_result   <= '0;
            roll_back    <= FALSE;
            roll_back_pc <= '0;
        end else if (rdy_in) begin
            rob_commit <= FALSE;
            roll_back  <= FALSE;
            if (w_mispredict) begin
                r_busy       <= '0;
                r_ready      <= '0;
                r_head       <= entry_t'(1);
                r_tail       <= entry_t'(1);
                r_count      <= '0;
                roll_back    <= TRUE;
                roll_back_pc <= r_target[r_head];
            end else begin
                if (w_wb) begin
                    r_ready[cdb_entry]  <= TRUE;
                    r_value[cdb_entry]  <= cdb_value;
                    r_taken[cdb_entry]  <= cdb_taken;
                    r_target[cdb_entry] <= cdb_target;
                end
                if (new_issue) begin
                    r_busy[r_tail]       <= TRUE;
                    r_ready[r_tail]      <= FALSE;
                    r_rd[r_tail]         <= issue_rd;
                    r_is_branch[r_tail]  <= issue_is_branch;
                    r_pred_taken[r_tail] <= issue_pred_taken;
                    r_tail               <= next_ptr(r_tail);
                end
                if (w_commit) begin
                    r_busy[r_head]  <= FALSE;
                    r_ready[r_head] <= FALSE;
                    r_head          <= next_ptr(r_head);
                    rob_commit      <= TRUE;
                    rob_entry       <= r_head;
                    rob_des         <= r_rd[r_head];
                    rob_result      <= r_value[r_head];
                end
                r_count <= r_count + {3'b0, new_issue} - {3'b0, w_commit};
            end
        end else begin
            rob_commit <= FALSE;
            roll_back  <= FALSE;
        end
    end
endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: random and directed stimulus checked every cycle against a program-order queue model
module tb_reorder_buffer;
    logic        clk = 1'b0;
    logic        rst_in, rdy_in, issue_valid, issue_is_branch, issue_pred_taken;
    logic [5:0]  issue_rd;
    logic        issue_ready, new_issue;
    logic [3:0]  rob_new_entry;
    logic        cdb_valid, cdb_taken;
    logic [3:0]  cdb_entry;
    logic [31:0] cdb_value, cdb_target;
    logic [3:0]  query_j_entry, query_k_entry;
    logic        query_j_ready, query_k_ready;
    logic [31:0] query_j_value, query_k_value;
    logic        rob_commit, roll_back;
    logic [3:0]  rob_entry;
    logic [5:0]  rob_des;
    logic [31:0] rob_result, roll_back_pc;

    reorder_buffer dut (
        .clk(clk), .rst_in(rst_in), .rdy_in(rdy_in),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_is_branch(issue_is_branch),
        .issue_pred_taken(issue_pred_taken), .issue_ready(issue_ready), .new_issue(new_issue),
        .rob_new_entry(rob_new_entry), .cdb_valid(cdb_valid), .cdb_entry(cdb_entry),
        .cdb_value(cdb_value), .cdb_taken(cdb_taken), .cdb_target(cdb_target),
        .query_j_entry(query_j_entry), .query_k_entry(query_k_entry),
        .query_j_ready(query_j_ready), .query_k_ready(query_k_ready),
        .query_j_value(query_j_value), .query_k_value(query_k_value),
        .rob_commit(rob_commit), .rob_entry(rob_entry), .rob_des(rob_des), .rob_result(rob_result),
        .roll_back(roll_back), .roll_back_pc(roll_back_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          tag;
        logic [5:0]  rd;
        bit          br, pred, rdy, tk;
        logic [31:0] val, tgt;
    } ent_t;

    ent_t        q[$];
    int          m_tail = 1;
    bit          m_rb, m_commit;
    logic [31:0] m_rb_pc, m_res;
    int          m_entry;
    logic [5:0]  m_des;
    int          n_tests = 0;
    int          n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit e_ready();
        return q.size() < 15 && !m_rb;
    endfunction

    function automatic bit e_new();
        return issue_valid && e_ready() && rdy_in;
    endfunction

    task automatic model_query(input logic [3:0] t, output bit r, output logic [31:0] v);
        r = 0;
        v = 0;
        if (t == 0) r = 1;
        else if (cdb_valid && cdb_entry == t) begin r = 1; v = cdb_value; end
        else foreach (q[i]) if (q[i].tag == int'(t)) begin r = q[i].rdy; v = q[i].val; end
    endtask

    task automatic model_step();
        bit ni, hd, mis, old_rb;
        ent_t h, n;
        if (rst_in) begin
            q.delete();
            m_tail = 1; m_rb = 0; m_rb_pc = 0; m_commit = 0; m_entry = 0; m_des = 0; m_res = 0;
            return;
        end
        ni = e_new();
        m_commit = 0;
        if (!rdy_in) begin m_rb = 0; return; end
        hd = q.size() > 0 && q[0].rdy;
        mis = hd && q[0].br && (q[0].tk != q[0].pred);
        if (mis) begin
            m_rb_pc = q[0].tgt; m_rb = 1; q.delete(); m_tail = 1;
            return;
        end
        old_rb = m_rb;
        m_rb = 0;
        if (hd) begin
            h = q.pop_front();
            m_commit = 1; m_entry = h.tag; m_des = h.rd; m_res = h.val;
        end
        if (cdb_valid && !old_rb)
            foreach (q[i]) if (q[i].tag == int'(cdb_entry)) begin
                q[i].rdy = 1; q[i].val = cdb_value; q[i].tk = cdb_taken; q[i].tgt = cdb_target;
            end
        if (ni) begin
            n.tag = m_tail; n.rd = issue_rd; n.br = issue_is_branch; n.pred = issue_pred_taken;
            n.rdy = 0; n.tk = 0; n.val = 0; n.tgt = 0;
            q.push_back(n);
            m_tail = (m_tail == 15) ? 1 : m_tail + 1;
        end
    endtask

    task automatic tick();
        bit er;
        logic [31:0] ev;
        #1;
        if (!rst_in) begin
            check("issue_ready", issue_ready, e_ready());
            check("new_issue", new_issue, e_new());
            check("rob_new_entry", rob_new_entry, m_tail);
            model_query(query_j_entry, er, ev);
            check("query_j_ready", query_j_ready, er);
            if (er) check("query_j_value", query_j_value, ev);
            model_query(query_k_entry, er, ev);
            check("query_k_ready", query_k_ready, er);
            if (er) check("query_k_value", query_k_value, ev);
        end
        @(posedge clk);
        model_step();
        #1;
        check("rob_commit", rob_commit, m_commit);
        check("roll_back", roll_back, m_rb);
        if (m_commit) begin
            check("rob_entry", rob_entry, m_entry);
            check("rob_des", rob_des, m_des);
            check("rob_result", rob_result, m_res);
        end
        if (m_rb || rst_in) check("roll_back_pc", roll_back_pc, m_rb_pc);
        if (rst_in) begin
            check("rob_entry_rst", rob_entry, 0);
            check("rob_des_rst", rob_des, 0);
            check("rob_result_rst", rob_result, 0);
        end
        @(negedge clk);
    endtask

    task automatic idle();
        issue_valid = 0; issue_rd = 0; issue_is_branch = 0; issue_pred_taken = 0;
        cdb_valid = 0; cdb_entry = 0; cdb_value = 0; cdb_taken = 0; cdb_target = 0;
        query_j_entry = 0; query_k_entry = 0;
    endtask

    task automatic do_reset();
        idle();
        rdy_in = 1;
        rst_in = 1;
        tick();
        rst_in = 0;
    endtask

    task automatic issue(input logic [5:0] rd, input bit br, input bit pred);
        issue_valid = 1; issue_rd = rd; issue_is_branch = br; issue_pred_taken = pred;
    endtask

    task automatic cdb(input logic [3:0] t, input logic [31:0] v, input bit tk, input logic [31:0] tg);
        cdb_valid = 1; cdb_entry = t; cdb_value = v; cdb_taken = tk; cdb_target = tg;
    endtask

    initial begin
        int idx;
        do_reset();
        #1;
        check("rst_commit", rob_commit, 0);
        check("rst_roll_back", roll_back, 0);
        check("rst_rob_entry", rob_entry, 0);
        check("rst_issue_ready", issue_ready, 1);
        check("rst_new_entry", rob_new_entry, 1);

        issue(5, 0, 0);
        #1;
        check("first_new_issue", new_issue, 1);
        check("first_tag", rob_new_entry, 1);
        tick();
        idle(); cdb(1, 32'h2A, 0, 0);
        tick();
        idle();
        tick();
        check("wb_commit_t2", rob_commit, 1);
        check("wb_commit_entry", rob_entry, 1);
        check("wb_commit_des", rob_des, 5);
        check("wb_commit_result", rob_result, 32'h2A);

        do_reset();
        for (int i = 1; i <= 3; i++) begin issue(6'(i), 0, 0); tick(); end
        idle(); cdb(3, 33, 0, 0); tick();
        idle(); cdb(2, 22, 0, 0); tick();
        idle(); cdb(1, 11, 0, 0); tick();
        idle();
        for (int i = 1; i <= 3; i++) begin
            tick();
            check("ooo_commit", rob_commit, 1);
            check("ooo_entry", rob_entry, i);
            check("ooo_result", rob_result, 11 * i);
        end

        do_reset();
        for (int i = 0; i < 15; i++) begin issue(6'(i + 1), 0, 0); tick(); end
        #1;
        check("full_issue_ready", issue_ready, 0);
        check("full_new_issue", new_issue, 0);
        cdb(1, 32'h99, 0, 0);
        tick();
        cdb_valid = 0;
        tick();
        #1;
        check("after_commit_new_issue", new_issue, 1);
        check("wrap_tag", rob_new_entry, 1);
        tick();
        idle();

        do_reset();
        issue(7, 0, 0); tick();
        issue(0, 1, 0); tick();
        issue(8, 0, 0); tick();
        idle(); cdb(2, 0, 1, 32'h100); tick();
        idle(); cdb(1, 32'h11, 0, 0); tick();
        idle(); tick();
        check("mp_commit1", rob_commit, 1);
        check("mp_commit1_entry", rob_entry, 1);
        tick();
        check("mp_roll_back", roll_back, 1);
        check("mp_roll_back_pc", roll_back_pc, 32'h100);
        check("mp_no_commit", rob_commit, 0);
        issue(9, 0, 0);
        #1;
        check("mp_issue_blocked", issue_ready, 0);
        tick();
        #1;
        check("mp_post_new_issue", new_issue, 1);
        check("mp_post_tag", rob_new_entry, 1);
        tick();
        idle();

        do_reset();
        for (int i = 0; i < 4; i++) begin issue(6'(i + 1), 0, 0); tick(); end
        idle(); cdb(4, 32'h77, 0, 0); query_j_entry = 4; query_k_entry = 0;
        #1;
        check("bypass_ready", query_j_ready, 1);
        check("bypass_value", query_j_value, 32'h77);
        check("null_ready", query_k_ready, 1);
        check("null_value", query_k_value, 0);
        tick();
        idle();

        do_reset();
        issue(3, 0, 0); tick();
        idle(); cdb(1, 32'h55, 0, 0); tick();
        idle(); rdy_in = 0;
        for (int i = 0; i < 3; i++) begin tick(); check("pause_no_commit", rob_commit, 0); end
        rdy_in = 1;
        tick();
        check("pause_resume_commit", rob_commit, 1);
        check("pause_resume_result", rob_result, 32'h55);

        do_reset();
        for (int i = 0; i < 5; i++) begin
            issue(6'(i + 10), 0, 0);
            if (i == 2) cdb(1, 32'hAB, 0, 0); else cdb_valid = 0;
            tick();
        end
        idle(); issue(20, 0, 0); tick();
        check("pre_rst_entry", rob_entry, 1);
        idle(); rst_in = 1; tick(); rst_in = 0;
        check("mid_rst_entry", rob_entry, 0);
        check("mid_rst_result", rob_result, 0);
        #1;
        check("mid_rst_tag", rob_new_entry, 1);

        for (int c = 0; c < 4000; c++) begin
            idle();
            rst_in = ($urandom_range(499) == 0);
            rdy_in = ($urandom_range(9) != 0);
            if ($urandom_range(2) != 0) begin
                if ($urandom_range(3) == 0) issue(0, 1, 1'($urandom));
                else issue(6'($urandom), 0, 0);
            end
            if ($urandom_range(1) == 0) begin
                if (q.size() > 0 && $urandom_range(4) != 0) begin
                    idx = $urandom_range(q.size() - 1);
                    cdb(4'(q[idx].tag), $urandom, q[idx].br ? (($urandom_range(4) == 0) ? !q[idx].pred : q[idx].pred) : 1'($urandom), $urandom);
                end else cdb(4'($urandom), $urandom, 1'($urandom), $urandom);
            end
            query_j_entry = 4'($urandom);
            query_k_entry = (q.size() > 0) ? 4'(q[$urandom_range(q.size() - 1)].tag) : 4'($urandom);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
